// File: rtl/squarer_arbiter_if.sv
// squarer_arbiter_if
//   Bundles the requester-side and squarer-side signals of squarer_arbiter.
//   slave  : arbiter view (drives grant/done/err/result/busy and the squarer start/operand)
//   master : environment view (requesters plus the sequential squarer)
//   Signals:
//     req       [M]    request levels, one per requester
//     a_flat    [M*N]  operands, requester i at a_flat[i*N +: N]
//     grant     [M]    one-hot, high while a requester is served
//     done      [M]    one-cycle result-valid pulse
//     err       [M]    one-cycle timeout-abort pulse
//     result    [2N]   last captured square
//     busy             arbiter not idle
//     sq_a      [N]    operand to the squarer
//     sq_start         squarer start level
//     sq_out    [2N]   squarer result
//     sq_finish        squarer completion
interface squarer_arbiter_if #(
    parameter int N = 4,
    parameter int M = 4
);
    logic [M-1:0]   req;
    logic [M*N-1:0] a_flat;
    logic [M-1:0]   grant;
    logic [M-1:0]   done;
    logic [M-1:0]   err;
    logic [2*N-1:0] result;
    logic           busy;
    logic [N-1:0]   sq_a;
    logic           sq_start;
    logic [2*N-1:0] sq_out;
    logic           sq_finish;

    modport slave (
        input  req, a_flat, sq_out, sq_finish,
        output grant, done, err, result, busy, sq_a, sq_start
    );

    modport master (
        output req, a_flat, sq_out, sq_finish,
        input  grant, done, err, result, busy, sq_a, sq_start
    );
endinterface

// File: rtl/squarer_arbiter.sv
// squarer_arbiter
//   Round-robin arbiter/sequencer sharing one sequential N-bit squarer among
//   M requesters. Latches the winner's operand, holds sq_start through the
//   operation, captures the 2N-bit square on sq_finish and pulses done for the
//   winner. A watchdog aborts an operation (err pulse) after TIMEOUT cycles.
//   Ports:
//     clk  : rising-edge clock
//     rst  : asynchronous active-high reset
//     bus  : squarer_arbiter_if.slave (requester and squarer signals)
//
//   state | meaning
//   IDLE  | waiting for any request; round-robin pick from last+1
//   RUN   | squarer started for the granted requester; watchdog counting
//   REL   | start released; waiting for the squarer to drop sq_finish
module squarer_arbiter #(
    parameter int N       = 4,
    parameter int M       = 4,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst,
    squarer_arbiter_if.slave   bus
);
    localparam int PW = $clog2(M);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, RUN, REL} state_t;

    state_t         state_q;
    logic [PW-1:0]  last_q;
    logic [CW-1:0]  cnt_q;
    logic [M-1:0]   grant_q;
    logic [M-1:0]   done_q;
    logic [M-1:0]   err_q;
    logic [2*N-1:0] result_q;
    logic           busy_q;
    logic [N-1:0]   sq_a_q;
    logic           sq_start_q;

    logic           win_vld_d;
    logic [PW-1:0]  win_idx_d;
    logic [M-1:0]   grant_d;
    logic [N-1:0]   op_d;
    int             scan_idx;

    // First requesting index after the last winner, wrapping mod M.
    always_comb begin
        win_vld_d = 1'b0;
        win_idx_d = last_q;
        scan_idx  = 0;
        for (int off = 1; off <= M; off++) begin
            scan_idx = (int'(last_q) + off) % M;
            if (!win_vld_d && bus.req[scan_idx]) begin
                win_vld_d = 1'b1;
                win_idx_d = PW'(scan_idx);
            end
        end
    end

    always_comb begin
        grant_d            = '0;
        grant_d[win_idx_d] = 1'b1;
        op_d               = bus.a_flat[win_idx_d*N +: N];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            last_q     <= PW'(M-1);
            cnt_q      <= '0;
            grant_q    <= '0;
            done_q     <= '0;
            err_q      <= '0;
            result_q   <= '0;
            busy_q     <= 1'b0;
            sq_a_q     <= '0;
            sq_start_q <= 1'b0;
        end else begin
            done_q <= '0;
            err_q  <= '0;
            case (state_q)
                IDLE: begin
                    if (win_vld_d) begin
                        grant_q    <= grant_d;
                        sq_a_q     <= op_d;
                        sq_start_q <= 1'b1;
                        last_q     <= win_idx_d;
                        cnt_q      <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    cnt_q <= cnt_q + CW'(1);
                    // Finish is checked first so it wins over a same-edge timeout.
                    if (bus.sq_finish) begin
                        result_q   <= bus.sq_out;
                        done_q     <= grant_q;
                        grant_q    <= '0;
                        sq_start_q <= 1'b0;
                        state_q    <= REL;
                    end else if (cnt_q == CW'(TIMEOUT-1)) begin
                        err_q      <= grant_q;
                        grant_q    <= '0;
                        sq_start_q <= 1'b0;
                        state_q    <= REL;
                    end
                end
                REL: begin
                    if (!bus.sq_finish) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.grant    = grant_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.result   = result_q;
    assign bus.busy     = busy_q;
    assign bus.sq_a     = sq_a_q;
    assign bus.sq_start = sq_start_q;
endmodule

// File: tb/tb_squarer_arbiter.sv
// tb_squarer_arbiter
//   Directed scenarios against squarer_arbiter (N=4, M=4, TIMEOUT=16) with a
//   behavioural squarer finishing N+1 cycles after start. Stimulus pushes the
//   expected grants and completions into queues; a negedge monitor pops and
//   compares them and also checks the always-true output relations.
module tb_squarer_arbiter;
    localparam int N   = 4;
    localparam int M   = 4;
    localparam int TO  = 16;
    localparam int LAT = N + 1;

    typedef struct packed {
        logic [3:0] g;
        logic [3:0] a;
    } gexp_t;

    typedef struct packed {
        logic [3:0] d;
        logic [3:0] e;
        logic [7:0] r;
        logic [7:0] lat;
    } dexp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic hang = 1'b0;
    int   cyc = 0;
    int   passed = 0;
    int   total = 0;

    gexp_t exp_g[$];
    dexp_t exp_d[$];

    squarer_arbiter_if #(.N(N), .M(M)) bus();

    squarer_arbiter #(.N(N), .M(M), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural squarer: finish rises LAT cycles after start, drops with start.
    int         m_cnt;
    logic       m_fin;
    logic [7:0] m_out;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt <= 0;
            m_fin <= 1'b0;
            m_out <= '0;
        end else if (!bus.sq_start) begin
            m_cnt <= 0;
            m_fin <= 1'b0;
        end else if (!hang && !m_fin && m_cnt == LAT-1) begin
            m_fin <= 1'b1;
            m_out <= {4'b0, bus.sq_a} * {4'b0, bus.sq_a};
        end else if (!m_fin) begin
            m_cnt <= m_cnt + 1;
        end
    end
    assign bus.sq_finish = m_fin & bus.sq_start;
    assign bus.sq_out    = m_out;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic set_op(input int i, input logic [3:0] v);
        bus.a_flat[i*N +: N] = v;
    endtask

    task automatic push_g(input logic [3:0] g, input logic [3:0] a);
        gexp_t t;
        t.g = g; t.a = a;
        exp_g.push_back(t);
    endtask

    task automatic push_d(input logic [3:0] d, input logic [3:0] e, input logic [7:0] r, input int lat);
        dexp_t t;
        t.d = d; t.e = e; t.r = r; t.lat = 8'(lat);
        exp_d.push_back(t);
    endtask

    // Wait for n completions, dropping requests in 'drop' as each completes.
    task automatic serve(input int n, input logic [3:0] drop, input int budget);
        int got = 0;
        int c = 0;
        while (got < n && c < budget) begin
            @(negedge clk);
            c++;
            if ((bus.done | bus.err) != 0) begin
                got++;
                bus.req = bus.req & ~((bus.done | bus.err) & drop);
            end
        end
        check("serve_count", got, n);
    endtask

    task automatic wait_grant(input int budget);
        int c = 0;
        while (bus.grant == 0 && c < budget) begin
            @(negedge clk);
            c++;
        end
        check("wait_grant", 32'(bus.grant != 0), 1);
    endtask

    task automatic check_empty(input string name);
        @(posedge clk);
        check({name, "_grant_q_empty"}, exp_g.size(), 0);
        check({name, "_done_q_empty"}, exp_d.size(), 0);
    endtask

    function automatic logic [25:0] all_outs();
        return {bus.grant, bus.done, bus.err, bus.result, bus.busy, bus.sq_a, bus.sq_start};
    endfunction

    // Monitor / scoreboard
    logic [3:0] prev_grant = '0;
    int         gcyc = 0;
    gexp_t      mg;
    dexp_t      md;
    always @(negedge clk) begin
        if (!rst) begin
            check("grant_onehot0", 32'($onehot0(bus.grant)), 1);
            check("done_err_excl", 32'(|(bus.done & bus.err)), 0);
            if ((bus.done | bus.err) != 0)
                check("released_on_complete", {bus.grant, bus.sq_start}, 0);
            if (bus.grant != 0 && prev_grant == 0) begin
                if (exp_g.size() == 0) begin
                    check("unexpected_grant", bus.grant, 0);
                end else begin
                    mg = exp_g.pop_front();
                    check("grant_vec", bus.grant, mg.g);
                    check("sq_a", bus.sq_a, mg.a);
                    check("sq_start_on_grant", bus.sq_start, 1);
                    check("busy_on_grant", bus.busy, 1);
                    gcyc = cyc;
                end
            end
            if ((bus.done | bus.err) != 0) begin
                if (exp_d.size() == 0) begin
                    check("unexpected_complete", {bus.done, bus.err}, 0);
                end else begin
                    md = exp_d.pop_front();
                    check("done_vec", bus.done, md.d);
                    check("err_vec", bus.err, md.e);
                    check("result", bus.result, md.r);
                    check("complete_latency", cyc - gcyc, md.lat);
                end
            end
        end
        prev_grant = bus.grant;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req    = '0;
        bus.a_flat = '0;
        #1 rst = 1'b1;
        #2 check("reset_outputs", all_outs(), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_after_reset", all_outs(), 0);

        // Simultaneous requests: served 0,1,2,3
        set_op(0, 4'd13); set_op(1, 4'd10); set_op(2, 4'd15); set_op(3, 4'd7);
        push_g(4'b0001, 4'd13); push_d(4'b0001, 4'b0, 8'd169, LAT+1);
        push_g(4'b0010, 4'd10); push_d(4'b0010, 4'b0, 8'd100, LAT+1);
        push_g(4'b0100, 4'd15); push_d(4'b0100, 4'b0, 8'd225, LAT+1);
        push_g(4'b1000, 4'd7);  push_d(4'b1000, 4'b0, 8'd49,  LAT+1);
        bus.req = 4'b1111;
        serve(4, 4'b1111, 200);
        check_empty("simul");

        // Fairness: 0 and 2 held, alternate
        @(negedge clk);
        set_op(0, 4'd3); set_op(2, 4'd5);
        for (int i = 0; i < 2; i++) begin
            push_g(4'b0001, 4'd3); push_d(4'b0001, 4'b0, 8'd9,  LAT+1);
            push_g(4'b0100, 4'd5); push_d(4'b0100, 4'b0, 8'd25, LAT+1);
        end
        bus.req = 4'b0101;
        serve(4, 4'b0000, 200);
        bus.req = '0;
        check_empty("fair");

        // Single request
        @(negedge clk);
        set_op(1, 4'd13);
        push_g(4'b0010, 4'd13); push_d(4'b0010, 4'b0, 8'd169, LAT+1);
        bus.req = 4'b0010;
        serve(1, 4'b0010, 100);
        check_empty("single");
        check("result_held", bus.result, 8'd169);

        // Timeout on requester 3, then pending requester 0 completes normally
        @(negedge clk);
        hang = 1'b1;
        set_op(3, 4'd9); set_op(0, 4'd6);
        push_g(4'b1000, 4'd9); push_d(4'b0, 4'b1000, 8'd169, TO);
        push_g(4'b0001, 4'd6); push_d(4'b0001, 4'b0, 8'd36, LAT+1);
        bus.req = 4'b1000;
        wait_grant(20);
        bus.req[0] = 1'b1;
        serve(1, 4'b1000, 100);
        hang = 1'b0;
        serve(1, 4'b0001, 100);
        check_empty("timeout");

        // Reset mid-RUN while serving requester 2
        @(negedge clk);
        set_op(2, 4'd11); set_op(3, 4'd4);
        push_g(4'b0100, 4'd11);
        bus.req = 4'b0100;
        wait_grant(20);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1 check("reset_mid_run", all_outs(), 0);
        push_g(4'b0100, 4'd11); push_d(4'b0100, 4'b0, 8'd121, LAT+1);
        push_g(4'b1000, 4'd4);  push_d(4'b1000, 4'b0, 8'd16,  LAT+1);
        bus.req = 4'b1100;
        @(negedge clk);
        rst = 1'b0;
        serve(2, 4'b1100, 100);
        check_empty("rst_run");

        repeat (3) @(negedge clk);
        check("final_idle", {bus.grant, bus.busy, bus.sq_start}, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/squarer_arbiter.md
# squarer_arbiter

Round-robin arbiter and sequencer that shares one sequential N-bit squarer (start/finish handshake, 2N-bit result) among M requesters. It latches the winning requester's operand and drives the squarer's start level. It captures the squared result on finish and returns it with a per-requester done pulse. A watchdog aborts any operation whose finish never arrives.

## Interface
Parameters:
- N, 4, operand width; result is 2N bits
- M, 4, number of requesters (≥2)
- TIMEOUT, 64, max cycles in RUN before abort (≥2); counter width $clog2(TIMEOUT)

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- req  input  M  per-requester request level
- a_flat  input  M*N  operands; requester i at a_flat[i*N +: N]
- grant  output  M  one-hot, high while requester is being served
- done  output  M  one-cycle pulse, result valid for that requester
- err  output  M  one-cycle pulse, timeout abort for that requester
- result  output  2N  last captured square, held until next capture
- busy  output  1  high in any state other than IDLE
- sq_a  output  N  operand to squarer, registered, stable through RUN
- sq_start  output  1  squarer start level
- sq_out  input  2N  squarer result
- sq_finish  input  1  squarer completion

## Operation
- Reset (async): state IDLE; grant, done, err, result, sq_a, sq_start, busy = 0; pointer last = M-1, so requester 0 has top priority first; timeout counter = 0.
- States: IDLE, RUN, REL.
- IDLE:
  - If any req bit is high, pick the first high bit scanning last+1, last+2, … with wrap mod M.
  - Register grant[w]=1, sq_a=operand w, sq_start=1, last=w, counter=0; go to RUN.
  - If no req bit is high, stay in IDLE.
- RUN:
  - sq_start held 1, sq_a and grant held; counter increments each cycle.
  - On sq_finish=1: result=sq_out, done[w]=1; go to REL.
  - Otherwise, if counter==TIMEOUT-1: err[w]=1, result unchanged; go to REL.
  - If finish and timeout occur on the same edge, finish wins: done, no err.
- REL:
  - grant=0, sq_start=0, done/err cleared after one cycle.
  - Stay until sq_finish=0, then go to IDLE.
- Requesters must hold req and the operand until their done/err pulse. Operands are sampled only in IDLE, so operand changes during RUN have no effect.
- req dropped during RUN: the operation still completes and done/err still pulses.
- req still high after done: it is a new request, but the pointer has moved, so the other pending requesters go first.
- Reset during RUN/REL: immediate return to reset values; the squarer sees sq_start fall asynchronously. No done or err is produced for the aborted operation.

## Timing
- Grant latency: req is sampled at edge k in IDLE; grant, sq_start and sq_a are valid after edge k.
- Completion: sq_finish is sampled high at edge j. After edge j, done[w] and result are valid, and grant and sq_start are low. done lasts exactly one cycle.
- Timeout: err[w] asserts after edge k+TIMEOUT, where k is the grant edge.
- Minimum turnaround, with sq_finish low at edge j+1: state IDLE after j+1, next grant after edge j+2. That gives at least one cycle of sq_start low between operations.
- Squarer latency is L cycles from sq_start rising to sq_finish high. Throughput per operation is L+3 cycles.
- At most one grant bit is ever high. done and err are never both high. done and grant are never high together.

## Test plan
Bench setup: N=4, M=4, behavioural squarer model with finish N+1 cycles after start. For every scenario, the bench also asserts grant is one-hot-or-zero, done and err are exclusive, and sq_start is low between operations.
- Reset: assert rst mid-clock → all outputs 0 immediately; after release with req=0 they stay 0.
- Single request: req=0010, a1=13 → grant=0010 one cycle later, sq_a=13, then done=0010 for one cycle with result=169; return to IDLE.
- Simultaneous requests: req=1111 with operands 13,10,15,7 → served in order 0,1,2,3 with results 169,100,225,49; exactly one grant at a time.
- Fairness: req0 and req2 held continuously (operands 3, 5) → grants alternate 0,2,0,2; results 9,25,9,25.
- Timeout: TIMEOUT=16, squarer model never finishes, req=1000, a3=9 → err=1000 sixteen cycles after grant; result unchanged; sq_start drops; a pending req0 is served next with a normal done.
- Reset mid-RUN: while serving requester 2, pulse rst, then hold req=1100 → no done for requester 2; the first grant after reset goes to 2 (pointer reset to 3, scan from 0); then 3.
